product_accumulator: RTL and testbench
======================================

Name: product_accumulator

Overview:
- Sits directly downstream of fast_multiplier.
- Consumes its product_o / product_valid_o stream and sums every VEC_LEN consecutive valid products into one dot-product result.
- Presents each result on a ready/valid output held in a single result register.
- The multiplier has no backpressure, so this block never stalls its input. A result not taken before the next one completes is overwritten and flagged.

Parameters:
- PROD_W, 16, width of incoming product (equals multiplier DOUT_W).
- VEC_LEN, 4, number of products per accumulated result; must be >= 2.
- ACC_W, PROD_W + $clog2(VEC_LEN), accumulator/result width; elaboration-time assertion ACC_W >= PROD_W + $clog2(VEC_LEN).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- product_i  input  PROD_W  product from multiplier, unsigned.
- product_valid_i  input  1  product_i valid this cycle; no ready returned.
- clear_i  input  1  synchronous abort of the partial vector.
- sum_o  output  ACC_W  accumulated result.
- sum_valid_o  output  1  sum_o holds an untaken result.
- sum_ready_i  input  1  consumer accepts sum_o when sum_valid_o && sum_ready_i.
- elem_count_o  output  $clog2(VEC_LEN)  products absorbed into the current partial vector.
- overrun_o  output  1  sticky: an untaken result was overwritten.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: acc_q=0, elem_count_o=0, sum_o=0, sum_valid_o=0, overrun_o=0. Reset mid-vector discards the partial sum and any held result.
- Arithmetic: product_i zero-extended to ACC_W before addition; unsigned, no wrap possible given the ACC_W rule.
- Input, clear_i=0, product_valid_i=1, elem_count_o < VEC_LEN-1: acc_q <= acc_q + product_i; count increments.
- Input, clear_i=0, product_valid_i=1, elem_count_o == VEC_LEN-1 (final element):
  - result register <= acc_q + product_i;
  - acc_q <= 0; count <= 0;
  - sum_valid_o <= 1.
- Latency: sum_valid_o rises the cycle after the final product is presented.
- product_valid_i=0: acc_q and count hold; gaps are allowed anywhere in a vector.
- clear_i=1: acc_q <= 0, count <= 0. A product_valid_i in the same cycle is dropped, including a would-be final element. The result register and overrun_o are unaffected.
- Output state machine, two states:
  - EMPTY (sum_valid_o=0): goes to FULL on final-element completion.
  - FULL (sum_valid_o=1): sum_o stable while waiting.
    - sum_ready_i=1, no completion this cycle -> EMPTY.
    - sum_ready_i=1 with completion -> stay FULL, load new result, no overrun.
    - sum_ready_i=0 with completion -> stay FULL, load new result, set overrun_o.
- overrun_o clears only on rst.
- sum_o: registered output, never combinational from product_i.

Decomposition:
- Add to multiplier_pkg: ACC_VEC_LEN (default 4) and an output-state enum typedef (ACC_OUT_EMPTY, ACC_OUT_FULL).
- No sub-module required; accumulator, counter and output FSM stay in one module.
- The result register is not a data_status_pipeline instance: it needs hold-on-backpressure.

Test Plan (PROD_W=16, VEC_LEN=4, ACC_W=18):
- Products 3,5,7,9 on consecutive cycles, sum_ready_i=1 -> sum_o=24, sum_valid_o high exactly one cycle, one cycle after the 9 is presented.
- Four products of 65535 -> sum_o=262140 (0x3FFFC), no truncation. Then 1,1,1,1 -> sum_o=4, confirming the accumulator restarts at 0.
- Products 10,20 with two idle cycles between, then 30,40, sum_ready_i=1 -> single result 100; elem_count_o steps 0,1,2,3,0.
- sum_ready_i=0; two full vectors (1,2,3,4 then 5,6,7,8) -> sum_o holds 10 until the second completion, then 26; overrun_o=1 and stays 1. Raising sum_ready_i -> sum_valid_o drops next cycle, overrun_o remains 1.
- Products 100,200, then clear_i=1 together with valid product 300, then 1,2,3,4 -> only result 10; 300 discarded.
- Products 7,7,7 then rst=1 for one cycle, then 1,1,1,1 -> all outputs 0 after reset; next result 4.
- Also cover: sum_ready_i=1 in the same cycle a new result completes while FULL -> new value loaded, sum_valid_o stays 1, overrun_o stays 0.

Source files
------------

// File: rtl/multiplier_pkg.sv
// Shared definitions for the multiplier datapath and its downstream accumulator.
package multiplier_pkg;

    // Default number of products folded into one accumulated result.
    localparam int ACC_VEC_LEN = 4;

    // State of the accumulator's single-entry result register.
    typedef enum logic [0:0] {
        ACC_OUT_EMPTY = 1'b0,
        ACC_OUT_FULL  = 1'b1
    } acc_out_state_e;

endpackage : multiplier_pkg

// File: rtl/product_accumulator.sv
// Sums every VEC_LEN consecutive valid products into one dot-product result.
// The input is never stalled. The result sits in a one-deep ready/valid
// register. A result that is still untaken when the next vector completes is
// overwritten, and the sticky overrun flag is set.
module product_accumulator
    import multiplier_pkg::*;
#(
    parameter int PROD_W  = 16,
    parameter int VEC_LEN = ACC_VEC_LEN,
    parameter int ACC_W   = PROD_W + $clog2(VEC_LEN)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PROD_W-1:0]          product_i,
    input  logic                       product_valid_i,
    input  logic                       clear_i,
    output logic [ACC_W-1:0]           sum_o,
    output logic                       sum_valid_o,
    input  logic                       sum_ready_i,
    output logic [$clog2(VEC_LEN)-1:0] elem_count_o,
    output logic                       overrun_o
);

    localparam int CNT_W = $clog2(VEC_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Reject parameter sets where the sum could wrap or the counter degenerates.
    generate
        if (VEC_LEN < 2) begin : g_bad_vec_len
            $error("product_accumulator: VEC_LEN must be >= 2");
        end
        if (ACC_W < PROD_W + $clog2(VEC_LEN)) begin : g_bad_acc_w
            $error("product_accumulator: ACC_W too narrow for VEC_LEN products");
        end
    endgenerate

    logic [ACC_W-1:0]  acc_q,   acc_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [ACC_W-1:0]  sum_q,   sum_d;
    logic              ovr_q,   ovr_d;
    acc_out_state_e    state_q, state_d;

    logic [ACC_W-1:0]  prod_ext_s;
    logic [ACC_W-1:0]  total_s;
    logic              complete_s;

    assign prod_ext_s = {{(ACC_W - PROD_W){1'b0}}, product_i};
    assign total_s    = acc_q + prod_ext_s;

    // Accumulator and element counter: absorb, finish a vector, or abort it.
    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        complete_s = 1'b0;
        if (clear_i) begin
            // A product arriving alongside clear is dropped, final or not.
            acc_d = {ACC_W{1'b0}};
            cnt_d = {CNT_W{1'b0}};
        end else if (product_valid_i) begin
            if (cnt_q == CNT_LAST) begin
                complete_s = 1'b1;
                acc_d      = {ACC_W{1'b0}};
                cnt_d      = {CNT_W{1'b0}};
            end else begin
                acc_d = total_s;
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            acc_d = acc_q;
            cnt_d = cnt_q;
        end
    end

    // Result register FSM: load on completion, drain on handshake, flag overwrites.
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        ovr_d   = ovr_q;
        case (state_q)
            ACC_OUT_EMPTY: begin
                if (complete_s) begin
                    state_d = ACC_OUT_FULL;
                    sum_d   = total_s;
                end else begin
                    state_d = ACC_OUT_EMPTY;
                end
            end
            ACC_OUT_FULL: begin
                if (complete_s) begin
                    // Stay full with the new value; it only counts as an
                    // overrun if the held result was not taken this cycle.
                    state_d = ACC_OUT_FULL;
                    sum_d   = total_s;
                    if (!sum_ready_i) begin
                        ovr_d = 1'b1;
                    end else begin
                        ovr_d = ovr_q;
                    end
                end else if (sum_ready_i) begin
                    state_d = ACC_OUT_EMPTY;
                end else begin
                    state_d = ACC_OUT_FULL;
                end
            end
            default: begin
                state_d = ACC_OUT_EMPTY;
            end
        endcase
    end

    // State registers with synchronous reset; reset drops partial and held results.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= {ACC_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            sum_q   <= {ACC_W{1'b0}};
            ovr_q   <= 1'b0;
            state_q <= ACC_OUT_EMPTY;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            ovr_q   <= ovr_d;
            state_q <= state_d;
        end
    end

    assign sum_o        = sum_q;
    assign sum_valid_o  = (state_q == ACC_OUT_FULL);
    assign elem_count_o = cnt_q;
    assign overrun_o    = ovr_q;

endmodule : product_accumulator

// File: tb/tb_product_accumulator.sv
// Directed-vector bench for product_accumulator (PROD_W=16, VEC_LEN=4, ACC_W=18).
module tb_product_accumulator;

    localparam int PROD_W  = 16;
    localparam int VEC_LEN = 4;
    localparam int ACC_W   = 18;

    logic              clk;
    logic              rst;
    logic [PROD_W-1:0] product_i;
    logic              product_valid_i;
    logic              clear_i;
    logic [ACC_W-1:0]  sum_o;
    logic              sum_valid_o;
    logic              sum_ready_i;
    logic [1:0]        elem_count_o;
    logic              overrun_o;

    int tests_run;
    int tests_failed;

    product_accumulator #(
        .PROD_W  (PROD_W),
        .VEC_LEN (VEC_LEN),
        .ACC_W   (ACC_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .product_i       (product_i),
        .product_valid_i (product_valid_i),
        .clear_i         (clear_i),
        .sum_o           (sum_o),
        .sum_valid_o     (sum_valid_o),
        .sum_ready_i     (sum_ready_i),
        .elem_count_o    (elem_count_o),
        .overrun_o       (overrun_o)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value and tally the result.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one input cycle, then advance to just after the clock edge.
    task automatic drive(input logic [PROD_W-1:0] p, input logic v, input logic c);
        product_i       = p;
        product_valid_i = v;
        clear_i         = c;
        @(posedge clk);
        #1;
    endtask

    // Present one idle cycle.
    task automatic idle();
        drive(16'd0, 1'b0, 1'b0);
    endtask

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        rst             = 1'b1;
        product_i       = 16'd0;
        product_valid_i = 1'b0;
        clear_i         = 1'b0;
        sum_ready_i     = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_sum",   32'(sum_o),        32'd0);
        chk("rst_valid", 32'(sum_valid_o),  32'd0);
        chk("rst_count", 32'(elem_count_o), 32'd0);
        chk("rst_ovr",   32'(overrun_o),    32'd0);

        // 3,5,7,9 -> 24, valid exactly one cycle after the 9
        drive(16'd3, 1'b1, 1'b0);
        chk("v1_cnt1", 32'(elem_count_o), 32'd1);
        drive(16'd5, 1'b1, 1'b0);
        drive(16'd7, 1'b1, 1'b0);
        chk("v1_cnt3",   32'(elem_count_o), 32'd3);
        chk("v1_novalid", 32'(sum_valid_o), 32'd0);
        drive(16'd9, 1'b1, 1'b0);
        chk("v1_valid", 32'(sum_valid_o),  32'd1);
        chk("v1_sum",   32'(sum_o),        32'd24);
        chk("v1_cnt0",  32'(elem_count_o), 32'd0);
        idle();
        chk("v1_drop", 32'(sum_valid_o), 32'd0);

        // Max products: 4 x 65535 = 262140, then 1,1,1,1 = 4
        for (int i = 0; i < 4; i++) drive(16'hFFFF, 1'b1, 1'b0);
        chk("max_sum",   32'(sum_o),       32'd262140);
        chk("max_valid", 32'(sum_valid_o), 32'd1);
        idle();
        for (int i = 0; i < 4; i++) drive(16'd1, 1'b1, 1'b0);
        chk("restart_sum", 32'(sum_o), 32'd4);
        idle();

        // Gaps: 10,20,idle,idle,30,40 -> 100
        drive(16'd10, 1'b1, 1'b0);
        chk("gap_cnt1", 32'(elem_count_o), 32'd1);
        drive(16'd20, 1'b1, 1'b0);
        chk("gap_cnt2a", 32'(elem_count_o), 32'd2);
        idle();
        idle();
        chk("gap_cnt2b", 32'(elem_count_o), 32'd2);
        chk("gap_novalid", 32'(sum_valid_o), 32'd0);
        drive(16'd30, 1'b1, 1'b0);
        chk("gap_cnt3", 32'(elem_count_o), 32'd3);
        drive(16'd40, 1'b1, 1'b0);
        chk("gap_cnt0", 32'(elem_count_o), 32'd0);
        chk("gap_sum",  32'(sum_o),        32'd100);
        chk("gap_valid", 32'(sum_valid_o), 32'd1);
        idle();
        chk("gap_drop", 32'(sum_valid_o), 32'd0);

        // Overrun: ready low across two vectors
        sum_ready_i = 1'b0;
        drive(16'd1, 1'b1, 1'b0);
        drive(16'd2, 1'b1, 1'b0);
        drive(16'd3, 1'b1, 1'b0);
        drive(16'd4, 1'b1, 1'b0);
        chk("ovr_sum10", 32'(sum_o),     32'd10);
        chk("ovr_pre",   32'(overrun_o), 32'd0);
        drive(16'd5, 1'b1, 1'b0);
        drive(16'd6, 1'b1, 1'b0);
        drive(16'd7, 1'b1, 1'b0);
        chk("ovr_hold10", 32'(sum_o),       32'd10);
        chk("ovr_holdv",  32'(sum_valid_o), 32'd1);
        drive(16'd8, 1'b1, 1'b0);
        chk("ovr_sum26", 32'(sum_o),     32'd26);
        chk("ovr_set",   32'(overrun_o), 32'd1);
        idle();
        chk("ovr_stick", 32'(overrun_o),   32'd1);
        chk("ovr_still", 32'(sum_valid_o), 32'd1);
        sum_ready_i = 1'b1;
        idle();
        chk("ovr_drain",  32'(sum_valid_o), 32'd0);
        chk("ovr_stick2", 32'(overrun_o),   32'd1);

        // Clear drops the partial vector and the product presented with it
        drive(16'd100, 1'b1, 1'b0);
        drive(16'd200, 1'b1, 1'b0);
        drive(16'd300, 1'b1, 1'b1);
        chk("clr_cnt",   32'(elem_count_o), 32'd0);
        chk("clr_novld", 32'(sum_valid_o),  32'd0);
        drive(16'd1, 1'b1, 1'b0);
        drive(16'd2, 1'b1, 1'b0);
        drive(16'd3, 1'b1, 1'b0);
        // Clear on a would-be final element also drops it
        drive(16'd50, 1'b1, 1'b1);
        chk("clr_final_cnt", 32'(elem_count_o), 32'd0);
        chk("clr_final_vld", 32'(sum_valid_o),  32'd0);
        for (int i = 1; i <= 4; i++) drive(16'(i), 1'b1, 1'b0);
        chk("clr_sum",   32'(sum_o),       32'd10);
        chk("clr_valid", 32'(sum_valid_o), 32'd1);
        chk("clr_ovr",   32'(overrun_o),   32'd1);
        idle();

        // Reset mid-vector clears everything, including sticky overrun
        drive(16'd7, 1'b1, 1'b0);
        drive(16'd7, 1'b1, 1'b0);
        drive(16'd7, 1'b1, 1'b0);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        chk("mrst_sum",   32'(sum_o),        32'd0);
        chk("mrst_valid", 32'(sum_valid_o),  32'd0);
        chk("mrst_cnt",   32'(elem_count_o), 32'd0);
        chk("mrst_ovr",   32'(overrun_o),    32'd0);
        for (int i = 0; i < 4; i++) drive(16'd1, 1'b1, 1'b0);
        chk("mrst_next", 32'(sum_o), 32'd4);
        idle();

        // Ready in the same cycle a new result completes while full: no overrun
        sum_ready_i = 1'b0;
        for (int i = 1; i <= 4; i++) drive(16'(i), 1'b1, 1'b0);
        chk("same_first", 32'(sum_o), 32'd10);
        drive(16'd5, 1'b1, 1'b0);
        drive(16'd6, 1'b1, 1'b0);
        drive(16'd7, 1'b1, 1'b0);
        sum_ready_i = 1'b1;
        drive(16'd8, 1'b1, 1'b0);
        chk("same_sum",   32'(sum_o),       32'd26);
        chk("same_valid", 32'(sum_valid_o), 32'd1);
        chk("same_ovr",   32'(overrun_o),   32'd0);
        idle();
        chk("same_drain", 32'(sum_valid_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_product_accumulator
